// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: deserializes SCLK/WS/SDATA into signed stereo sample pairs
//
// Purpose: samples the codec's asynchronous I2S stream in the clk domain. It
// checks that each WS half-frame is exactly SLOT_BITS SCLK periods long. It
// presents each complete left/right pair with a one-clk vld strobe.
//
// Ports:
//   clk        system clock, at least 8x the SCLK rate
//   rst_n      asynchronous active-low reset
//   I2S_sclk   codec bit clock (asynchronous)
//   I2S_ws     word select, 0 = left, 1 = right (asynchronous)
//   I2S_data   serial data, MSB first, one-bit delayed after WS (asynchronous)
//   lft_chnnl  left sample, held between vld strobes
//   rght_chnnl right sample, held between vld strobes
//   vld        one-clk strobe: new lft_chnnl/rght_chnnl pair
//   err        one-clk strobe: slot length error, receiver resynchronizes
module i2s_rx #(
  parameter int SLOT_BITS = 24,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 I2S_sclk,
  input  logic                 I2S_ws,
  input  logic                 I2S_data,
  output logic [DATA_BITS-1:0] lft_chnnl,
  output logic [DATA_BITS-1:0] rght_chnnl,
  output logic                 vld,
  output logic                 err
);

  localparam int CW = $clog2(SLOT_BITS + 1);

  // A slot is closed by the WS edge that arrives when the pre-increment count
  // is SLOT_BITS-1. The same count on a non-transition rise means the slot
  // would run past SLOT_BITS.
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] DATA_MAX  = CW'(DATA_BITS);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t               state;
  logic                 sclk_s1, sclk_s2, sclk_s3;
  logic                 ws_s1, ws_s2;
  logic                 data_s1, data_s2;
  logic                 ws_prev;
  logic [CW-1:0]        slot_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] sh_l;
  logic [DATA_BITS-1:0] sh_r;
  logic                 rise;

  // WS and data ride through the same number of flops as SCLK. Both are
  // stable around the SCLK rise, so they are sampled consistently with it.
  assign rise = sclk_s2 & ~sclk_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SYNC;
      sclk_s1    <= 1'b0;
      sclk_s2    <= 1'b0;
      sclk_s3    <= 1'b0;
      ws_s1      <= 1'b0;
      ws_s2      <= 1'b0;
      data_s1    <= 1'b0;
      data_s2    <= 1'b0;
      ws_prev    <= 1'b0;
      slot_cnt   <= '0;
      bit_cnt    <= '0;
      sh_l       <= '0;
      sh_r       <= '0;
      lft_chnnl  <= '0;
      rght_chnnl <= '0;
      vld        <= 1'b0;
      err        <= 1'b0;
    end else begin
      sclk_s1 <= I2S_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ws_s1   <= I2S_ws;
      ws_s2   <= ws_s1;
      data_s1 <= I2S_data;
      data_s2 <= data_s1;
      vld     <= 1'b0;
      err     <= 1'b0;

      if (rise) begin
        ws_prev <= ws_s2;
        case (state)
          SYNC: begin
            // Only a WS falling edge marks a frame start. The bit on this
            // rise belongs to the previous word and is dropped.
            if (ws_prev && !ws_s2) begin
              slot_cnt <= '0;
              bit_cnt  <= '0;
              state    <= LEFT;
            end
          end

          LEFT: begin
            if (ws_s2 && !ws_prev) begin
              slot_cnt <= '0;
              bit_cnt  <= '0;
              if (slot_cnt == SLOT_LAST) begin
                state <= RIGHT;
              end else begin
                err   <= 1'b1;
                state <= SYNC;
              end
            end else if (slot_cnt == SLOT_LAST) begin
              err   <= 1'b1;
              state <= SYNC;
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
              if (bit_cnt < DATA_MAX) begin
                sh_l    <= {sh_l[DATA_BITS-2:0], data_s2};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end

          RIGHT: begin
            if (!ws_s2 && ws_prev) begin
              slot_cnt <= '0;
              bit_cnt  <= '0;
              if (slot_cnt == SLOT_LAST) begin
                // Frame complete. This falling edge also opens the next
                // left slot, so stay aligned without passing through SYNC.
                lft_chnnl  <= sh_l;
                rght_chnnl <= sh_r;
                vld        <= 1'b1;
                state      <= LEFT;
              end else begin
                err   <= 1'b1;
                state <= SYNC;
              end
            end else if (slot_cnt == SLOT_LAST) begin
              err   <= 1'b1;
              state <= SYNC;
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
              if (bit_cnt < DATA_MAX) begin
                sh_r    <= {sh_r[DATA_BITS-2:0], data_s2};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end

          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule
